// File: rtl/cascade_ctrl.sv
// PIC cascade controller: role resolution, INTA pulse FSM, CAS bus drive/match.
// Optional build macro CASCADE_TIMEOUT_EN adds a watchdog that aborts a sequence stuck in G1/G2.
module cascade_ctrl #(
    parameter int CAS_W      = 3,
    parameter int NUM_SLAVES = 2**CAS_W,
    parameter int TO_CYC     = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sp_en_n,
    input  logic                  buf_mode,
    input  logic                  ms_cfg,
    input  logic                  sngl,
    input  logic                  mode8080,
    input  logic [NUM_SLAVES-1:0] slave_map,
    input  logic [CAS_W-1:0]      slave_id,
    input  logic [CAS_W-1:0]      ack_irq,
    input  logic                  ack_vld,
    input  logic                  inta_n,
    input  logic [CAS_W-1:0]      cas_i,
    output logic [CAS_W-1:0]      cas_o,
    output logic                  cas_oe,
    output logic                  is_master,
    output logic                  vec_en,
    output logic                  cas_rel,
    output logic                  to_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_G1   = 3'd2,
        S_P2   = 3'd3,
        S_G2   = 3'd4,
        S_P3   = 3'd5
    } state_t;

    if ((NUM_SLAVES != 2**CAS_W) || (TO_CYC < 1)) begin : g_bad_cfg
        $error("cascade_ctrl: NUM_SLAVES must equal 2**CAS_W and TO_CYC must be positive");
    end

    state_t             state_r;
    state_t             state_nxt_s;
    logic               inta_q_r;
    logic               fall_s;
    logic               rise_s;
    logic               role_s;
    logic               start_s;
    logic               samp_s;
    logic               id_hit_s;
    logic               to_hit_s;
    logic               oe_s;
    logic               vec_s;
    logic               mode_r;
    logic               sngl_r;
    logic               casc_r;
    logic               match_r;
    logic               rel_pend_r;
    logic [CAS_W-1:0]   ack_r;
    logic [CAS_W-1:0]   cas_o_r;
    logic               cas_oe_r;
    logic               is_master_r;
    logic               vec_en_r;
    logic               cas_rel_r;

    assign fall_s   = inta_q_r & ~inta_n;
    assign rise_s   = ~inta_q_r & inta_n;
    assign role_s   = sngl ? 1'b1 : (buf_mode ? ms_cfg : sp_en_n);
    assign start_s  = (state_r == S_IDLE) & fall_s;
    assign samp_s   = (state_r == S_G1) & fall_s;
    assign id_hit_s = (cas_i == slave_id) & ~is_master_r;

`ifdef CASCADE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_r;
    logic             to_err_r;

    assign to_hit_s = ((state_r == S_G1) || (state_r == S_G2)) && (cnt_r == CNT_W'(TO_CYC));
    assign to_err   = to_err_r;

    // Watchdog: cycles spent in the current state, restarted on every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            to_err_r <= 1'b0;
        end else begin
            to_err_r <= to_hit_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    assign to_hit_s = 1'b0;
    assign to_err   = 1'b0;
`endif

    // INTA pulse sequencer next state; watchdog abort only applies in the gaps.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  state_nxt_s = fall_s ? S_P1 : S_IDLE;
            S_P1:    state_nxt_s = rise_s ? S_G1 : S_P1;
            S_G1: begin
                if (to_hit_s)    state_nxt_s = S_IDLE;
                else if (fall_s) state_nxt_s = S_P2;
                else             state_nxt_s = S_G1;
            end
            S_P2: begin
                if (rise_s)      state_nxt_s = mode_r ? S_G2 : S_IDLE;
                else             state_nxt_s = S_P2;
            end
            S_G2: begin
                if (to_hit_s)    state_nxt_s = S_IDLE;
                else if (fall_s) state_nxt_s = S_P3;
                else             state_nxt_s = S_G2;
            end
            S_P3:    state_nxt_s = rise_s ? S_IDLE : S_P3;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    assign oe_s  = (state_r != S_IDLE) & is_master_r & casc_r & ~sngl_r & ~to_hit_s;
    assign vec_s = ((state_r == S_P2) || (state_r == S_P3)) & (is_master_r ? ~casc_r : match_r);

    // Sequence state, frozen role/config snapshot and registered pad/bus controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            inta_q_r    <= 1'b1;
            is_master_r <= 1'b1;
            mode_r      <= 1'b0;
            sngl_r      <= 1'b0;
            casc_r      <= 1'b0;
            ack_r       <= {CAS_W{1'b0}};
            match_r     <= 1'b0;
            rel_pend_r  <= 1'b0;
            cas_o_r     <= {CAS_W{1'b0}};
            cas_oe_r    <= 1'b0;
            vec_en_r    <= 1'b0;
            cas_rel_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inta_q_r   <= inta_n;
            rel_pend_r <= samp_s & id_hit_s;
            cas_rel_r  <= rel_pend_r;
            cas_oe_r   <= oe_s;
            cas_o_r    <= oe_s ? ack_r : {CAS_W{1'b0}};
            vec_en_r   <= vec_s;
            // The held role doubles as the role snapshot for the whole sequence.
            if ((state_r == S_IDLE) && !fall_s) begin
                is_master_r <= role_s;
            end
            if (start_s) begin
                mode_r  <= mode8080;
                sngl_r  <= sngl;
                ack_r   <= ack_irq;
                casc_r  <= is_master_r & ~sngl & ack_vld & slave_map[ack_irq];
                match_r <= 1'b0;
            end else if (samp_s) begin
                match_r <= id_hit_s;
            end
        end
    end

    assign cas_o     = cas_o_r;
    assign cas_oe    = cas_oe_r;
    assign is_master = is_master_r;
    assign vec_en    = vec_en_r;
    assign cas_rel   = cas_rel_r;

endmodule

// File: tb/tb_cascade_ctrl.sv
// Self-checking bench for cascade_ctrl: scenario table driven through a per-cycle
// expectation queue, plus reset-mid-sequence and (with CASCADE_TIMEOUT_EN) watchdog sequences.
module tb_cascade_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sp_en_n, buf_mode, ms_cfg, sngl, mode8080;
    logic [7:0] slave_map;
    logic [2:0] slave_id, ack_irq, cas_i;
    logic       ack_vld, inta_n;
    logic [2:0] cas_o;
    logic       cas_oe, is_master, vec_en, cas_rel, to_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] cas_o;
        logic       cas_oe;
        logic       vec_en;
        logic       cas_rel;
        logic       is_master;
        logic       to_err;
    } obs_t;

    typedef struct packed {
        logic chk;
        obs_t o;
    } exp_t;

    typedef struct {
        logic       sp_en_n, buf_mode, ms_cfg, sngl, mode8080;
        logic [7:0] slave_map;
        logic [2:0] slave_id, ack_irq;
        logic       ack_vld;
        logic [2:0] cas_i;
        logic       exp_master, exp_casc, exp_vec, exp_rel;
        string      name;
    } vec_t;

    vec_t tbl[9];
    exp_t q[$];

    cascade_ctrl #(.CAS_W(3), .NUM_SLAVES(8), .TO_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .sp_en_n(sp_en_n), .buf_mode(buf_mode), .ms_cfg(ms_cfg),
        .sngl(sngl), .mode8080(mode8080), .slave_map(slave_map), .slave_id(slave_id),
        .ack_irq(ack_irq), .ack_vld(ack_vld), .inta_n(inta_n), .cas_i(cas_i),
        .cas_o(cas_o), .cas_oe(cas_oe), .is_master(is_master), .vec_en(vec_en),
        .cas_rel(cas_rel), .to_err(to_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur();
        obs_t o;
        o.cas_o = cas_o; o.cas_oe = cas_oe; o.vec_en = vec_en;
        o.cas_rel = cas_rel; o.is_master = is_master; o.to_err = to_err;
        return o;
    endfunction

    task automatic check_obs(input string nm, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got cas_o=%0d oe=%b vec=%b rel=%b m=%b to=%b, want cas_o=%0d oe=%b vec=%b rel=%b m=%b to=%b",
                     nm, $time, a.cas_o, a.cas_oe, a.vec_en, a.cas_rel, a.is_master, a.to_err,
                     e.cas_o, e.cas_oe, e.vec_en, e.cas_rel, e.is_master, e.to_err);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    // One clock: drive inta_n, queue this cycle's expectation, compare the one from two cycles ago.
    task automatic step(input logic lv, input exp_t e, input string nm);
        exp_t x;
        @(posedge clk); #1;
        inta_n = lv;
        q.push_back(e);
        @(negedge clk);
        if (q.size() > 2) begin
            x = q.pop_front();
            if (x.chk) check_obs(nm, cur(), x.o);
        end
    endtask

    task automatic set_cfg(input vec_t s);
        exp_t idle_e;
        idle_e = '0;
        @(posedge clk); #1;
        sp_en_n = s.sp_en_n; buf_mode = s.buf_mode; ms_cfg = s.ms_cfg; sngl = s.sngl;
        mode8080 = s.mode8080; slave_map = s.slave_map; slave_id = s.slave_id;
        ack_irq = s.ack_irq; ack_vld = s.ack_vld; cas_i = s.cas_i; inta_n = 1'b1;
        q.delete();
        for (int i = 0; i < 4; i++) step(1'b1, idle_e, s.name);
    endtask

    // Full INTA sequence; expectation for cycle t depends only on where inta_n stood at t.
    task automatic run_scn(input vec_t s, input int gap);
        logic lv_q[$];
        logic prev, lv, in_seq, first_low;
        int   np, k;
        exp_t e;
        set_cfg(s);
        np = s.mode8080 ? 3 : 2;
        lv_q = {1'b1, 1'b1};
        for (int p = 1; p <= np; p++) begin
            for (int i = 0; i < 3; i++) lv_q.push_back(1'b0);
            if (p < np) for (int i = 0; i < gap; i++) lv_q.push_back(1'b1);
        end
        for (int i = 0; i < 5; i++) lv_q.push_back(1'b1);
        k = 0;
        prev = 1'b1;
        foreach (lv_q[i]) begin
            lv = lv_q[i];
            first_low = prev & ~lv;
            if (first_low) k++;
            in_seq = (k >= 1) && !(lv && (k == np));
            e.chk         = 1'b1;
            e.o.cas_oe    = s.exp_casc & in_seq;
            e.o.cas_o     = e.o.cas_oe ? s.ack_irq : 3'd0;
            e.o.vec_en    = s.exp_vec & ~lv & (k >= 2);
            e.o.cas_rel   = s.exp_rel & first_low & (k == 2);
            e.o.is_master = s.exp_master;
            e.o.to_err    = 1'b0;
            step(lv, e, s.name);
            prev = lv;
        end
    endtask

    initial begin
        exp_t  nochk;
        obs_t  rst_o;
        int    nto;
        logic  saw_oe;
        logic  pre_lv[11];

        nochk = '0;
        rst_o = '0;
        rst_o.is_master = 1'b1;

        //          sp  buf ms  sng 80  map    id    ack   vld cas_i  mst casc vec rel
        tbl[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h08,3'd0,3'd3,1'b1,3'd0,1'b1,1'b1,1'b0,1'b0,"m86_casc"};
        tbl[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,3'd0,3'd5,1'b1,3'd0,1'b1,1'b0,1'b1,1'b0,"m86_noslave"};
        tbl[2] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,3'd2,3'd0,1'b0,3'd2,1'b0,1'b0,1'b1,1'b1,"s80_match"};
        tbl[3] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,3'd2,3'd0,1'b0,3'd6,1'b0,1'b0,1'b0,1'b0,"s80_miss"};
        tbl[4] = '{1'b1,1'b1,1'b0,1'b0,1'b0,8'hFF,3'd5,3'd5,1'b1,3'd5,1'b0,1'b0,1'b1,1'b1,"buf_slave"};
        tbl[5] = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'hFF,3'd0,3'd3,1'b1,3'd0,1'b1,1'b0,1'b1,1'b0,"single"};
        tbl[6] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h80,3'd0,3'd7,1'b1,3'd0,1'b1,1'b1,1'b0,1'b0,"m80_casc"};
        tbl[7] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'hFF,3'd0,3'd1,1'b0,3'd0,1'b1,1'b0,1'b1,1'b0,"m80_novld"};
        tbl[8] = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h04,3'd0,3'd2,1'b1,3'd0,1'b1,1'b1,1'b0,1'b0,"buf_master"};

        rst_n = 1'b0;
        sp_en_n = 1'b0; buf_mode = 1'b0; ms_cfg = 1'b0; sngl = 1'b0; mode8080 = 1'b0;
        slave_map = 8'h00; slave_id = 3'd0; ack_irq = 3'd0; ack_vld = 1'b0;
        cas_i = 3'd0; inta_n = 1'b1;
        repeat (3) @(negedge clk);
        check_obs("reset_state", cur(), rst_o);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_scn(tbl[i], 3);

`ifndef CASCADE_TIMEOUT_EN
        run_scn(tbl[0], 40);
`endif

        // Reset while P2 is driving the CAS bus.
        set_cfg(tbl[0]);
        pre_lv = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
        foreach (pre_lv[i]) step(pre_lv[i], nochk, "pre_reset");
        check_int("p2_oe_before_reset", int'(cas_oe), 1);
        check_int("p2_cas_o_before_reset", int'(cas_o), 3);
        #2 rst_n = 1'b0;
        #1 check_obs("async_reset_clear", cur(), rst_o);
        @(posedge clk);
        @(negedge clk);
        inta_n = 1'b1;
        rst_n  = 1'b1;
        run_scn(tbl[0], 3);

`ifdef CASCADE_TIMEOUT_EN
        // Abandon the sequence after the first pulse; watchdog must abort it once.
        set_cfg(tbl[0]);
        nto = 0;
        saw_oe = 1'b0;
        step(1'b1, nochk, "to_pre");
        step(1'b1, nochk, "to_pre");
        for (int i = 0; i < 3; i++) step(1'b0, nochk, "to_pulse");
        for (int i = 0; i < 40; i++) begin
            step(1'b1, nochk, "to_wait");
            if (to_err) nto++;
            if (cas_oe) saw_oe = 1'b1;
        end
        check_int("to_oe_seen", int'(saw_oe), 1);
        check_int("to_err_pulses", nto, 1);
        check_int("to_oe_dropped", int'(cas_oe), 0);
        run_scn(tbl[0], 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
